// File: rtl/line_buffer_ctrl.sv
// Frame sequencer for the HOG line-buffer chain: pixel handshake, raster counters, window qualifiers.
// Optional statistics (frame_count, stall_count) are compiled in when LB_CTRL_STATS_EN is defined.
module line_buffer_ctrl #(
    parameter  int DATA_WIDTH   = 8,
    parameter  int IMG_WIDTH    = 854,
    parameter  int IMG_HEIGHT   = 480,
    parameter  int KERNEL_WIDTH = 3,
    localparam int XW           = $clog2(IMG_WIDTH),
    localparam int YW           = $clog2(IMG_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] lb_w_data,
    output logic                  lb_w_valid,
    input  logic                  lb_w_ready,
    output logic                  busy,
    output logic                  win_valid,
    output logic                  win_border,
    output logic [XW-1:0]         win_x,
    output logic [YW-1:0]         win_y,
    output logic                  frame_done
`ifdef LB_CTRL_STATS_EN
    ,
    output logic [15:0]           frame_count,
    output logic [31:0]           stall_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        DONE
    } state_t;

    localparam logic [XW-1:0] COL_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] ROW_LAST = YW'(IMG_HEIGHT - 1);
    localparam logic [YW-1:0] FILL_ROW = YW'(KERNEL_WIDTH - 2);
    localparam logic [XW-1:0] KM1_X    = XW'(KERNEL_WIDTH - 1);
    localparam logic [YW-1:0] KM1_Y    = YW'(KERNEL_WIDTH - 1);

    state_t        state, state_next;
    logic [XW-1:0] col;
    logic [YW-1:0] row;
    logic          accept;
    logic          col_last;
    logic          row_last;
    logic          in_run;

    assign busy       = (state == FILL) || (state == RUN);
    assign in_run     = (state == RUN);
    assign s_ready    = lb_w_ready && busy;
    assign accept     = s_valid && s_ready;
    assign lb_w_valid = accept;
    assign lb_w_data  = s_data;
    assign col_last   = (col == COL_LAST);
    assign row_last   = (row == ROW_LAST);
    // DONE is entered on the last accept, so frame_done lines up with that pixel's window.
    assign frame_done = (state == DONE);

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start) state_next = FILL;
            FILL: if (accept && row == FILL_ROW && col_last) state_next = RUN;
            RUN:  if (accept && row_last && col_last) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (state == IDLE && start) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Qualifiers trail the accept by one cycle to meet the line-buffer read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_valid  <= 1'b0;
            win_border <= 1'b0;
            win_x      <= '0;
            win_y      <= '0;
        end else begin
            win_valid  <= accept && in_run && (col >= KM1_X);
            win_border <= accept && in_run && (col < KM1_X);
            if (accept && in_run && (col >= KM1_X)) begin
                win_x <= col - KM1_X;
                win_y <= row - KM1_Y;
            end else begin
                win_x <= '0;
                win_y <= '0;
            end
        end
    end

`ifdef LB_CTRL_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_count <= '0;
            stall_count <= '0;
        end else begin
            if (state == DONE) begin
                frame_count <= frame_count + 1'b1;
            end
            if (state == IDLE && start) begin
                stall_count <= '0;
            end else if (busy && s_valid && !lb_w_ready && stall_count != '1) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Self-checking bench for line_buffer_ctrl on an 8x6 frame with a 3x3 kernel.
// Define LB_CTRL_STATS_EN for both files to also exercise the statistics counters.
module tb_line_buffer_ctrl;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int K  = 3;
    localparam int DW = 8;
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);

    logic          clk;
    logic          rst;
    logic          start;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] lb_w_data;
    logic          lb_w_valid;
    logic          lb_w_ready;
    logic          busy;
    logic          win_valid;
    logic          win_border;
    logic [XW-1:0] win_x;
    logic [YW-1:0] win_y;
    logic          frame_done;
`ifdef LB_CTRL_STATS_EN
    logic [15:0]   frame_count;
    logic [31:0]   stall_count;
`endif

    line_buffer_ctrl #(
        .DATA_WIDTH  (DW),
        .IMG_WIDTH   (W),
        .IMG_HEIGHT  (H),
        .KERNEL_WIDTH(K)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .lb_w_data (lb_w_data),
        .lb_w_valid(lb_w_valid),
        .lb_w_ready(lb_w_ready),
        .busy      (busy),
        .win_valid (win_valid),
        .win_border(win_border),
        .win_x     (win_x),
        .win_y     (win_y),
        .frame_done(frame_done)
`ifdef LB_CTRL_STATS_EN
        ,
        .frame_count(frame_count),
        .stall_count(stall_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit border_pixel(input int idx);
        return idx inside {16, 17, 24, 25, 32, 33, 40, 41};
    endfunction

    // Reference model: tracks the frame by pixel index and derives row/col arithmetically.
    bit          m_busy, m_done;
    int          m_n;
    bit          e_wv, e_wb, e_fd;
    int          e_wx, e_wy;
    int          m_frames;
    logic [31:0] m_stall;

    always @(posedge clk or posedge rst) begin
        bit idle, acc;
        int r, c;
        if (rst) begin
            m_busy = 0; m_done = 0; m_n = 0;
            e_wv = 0; e_wb = 0; e_fd = 0; e_wx = 0; e_wy = 0;
            m_frames = 0; m_stall = 0;
        end else begin
            idle = !m_busy && !m_done;
            acc  = m_busy && lb_w_ready && s_valid;
            if (m_busy && s_valid && !lb_w_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (m_done) m_frames = (m_frames + 1) % 65536;
            r = m_n / W;
            c = m_n % W;
            e_wv = acc && r >= K - 1 && c >= K - 1;
            e_wb = acc && r >= K - 1 && c < K - 1;
            e_wx = e_wv ? c - (K - 1) : 0;
            e_wy = e_wv ? r - (K - 1) : 0;
            m_done = acc && (m_n == W * H - 1);
            e_fd = m_done;
            if (acc) m_n++;
            if (m_done) m_busy = 0;
            if (idle && start) begin
                m_busy = 1; m_n = 0; m_stall = 0;
            end
        end
    end

    bit cmp_en = 0;
    int cnt_wv, cnt_wb, acc_cnt, done_cnt;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("s_ready", s_ready, m_busy && lb_w_ready);
            check("lb_w_valid", lb_w_valid, m_busy && lb_w_ready && s_valid);
            check("lb_w_data", lb_w_data, s_data);
            check("busy", busy, m_busy);
            check("win_valid", win_valid, e_wv);
            check("win_border", win_border, e_wb);
            check("win_x", win_x, e_wx);
            check("win_y", win_y, e_wy);
            check("frame_done", frame_done, e_fd);
`ifdef LB_CTRL_STATS_EN
            check("frame_count", frame_count, m_frames);
            check("stall_count", stall_count, m_stall);
`endif
            if (rst) begin
                cnt_wv = 0; cnt_wb = 0; acc_cnt = 0;
            end else begin
                if (win_valid) begin
                    if (cnt_wv == 0) begin
                        check("first_win_after_pix18", acc_cnt, 19);
                        check("first_win_x", win_x, 0);
                        check("first_win_y", win_y, 0);
                    end
                    cnt_wv++;
                end
                if (win_border) begin
                    check("border_pixel_index", border_pixel(acc_cnt - 1), 1);
                    cnt_wb++;
                end
                if (frame_done) begin
                    check("done_with_win_valid", win_valid, 1);
                    check("last_win_x", win_x, 5);
                    check("last_win_y", win_y, 3);
                    check("frame_win_valid_total", cnt_wv, 24);
                    check("frame_win_border_total", cnt_wb, 8);
                    done_cnt++;
                    cnt_wv = 0; cnt_wb = 0; acc_cnt = 0;
                end
                if (lb_w_valid) acc_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame; optional stall before pixel stall_at, stray start at start_at,
    // and early return before pixel abort_at.
    task automatic run_frame(input int stall_at, input int stall_len, input int start_at, input int abort_at);
        int d0;
        bit seen;
        start = 1; s_valid = 0;
        tick();
        start = 0;
        for (int n = 0; n < W * H; n++) begin
            if (n == abort_at) begin
                s_valid = 0;
                return;
            end
            s_data = DW'(n * 13 + 5);
            s_valid = 1;
            if (n == stall_at) begin
                lb_w_ready = 0;
                repeat (stall_len) tick();
                lb_w_ready = 1;
            end
            start = (n == start_at);
            tick();
            start = 0;
        end
        s_valid = 0;
        d0 = done_cnt;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            seen = (done_cnt != d0);
        end
        check("frame_done_timeout", seen, 1);
        repeat (2) tick();
    endtask

    initial begin
        int wr;
        rst = 1; start = 0; s_valid = 0; s_data = '0; lb_w_ready = 1;
        done_cnt = 0;
        tick();
        cmp_en = 1;
        repeat (2) tick();
        check("rst_s_ready", s_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_win_valid", win_valid, 0);
        check("rst_frame_done", frame_done, 0);

        // 1: idle without start never writes
        rst = 0; s_valid = 1; s_data = 8'hA5;
        wr = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (lb_w_valid) wr++;
        end
        check("idle_no_writes", wr, 0);
        tick();
        s_valid = 0;

        // 2: back-to-back frame
        run_frame(-1, 0, -1, -1);
        check("done_count_s2", done_cnt, 1);

        // 3: stall at pixel 21
        run_frame(21, 5, -1, -1);
        check("done_count_s3", done_cnt, 2);

        // 4: stray start mid-frame, then a second frame
        run_frame(-1, 0, 10, -1);
        run_frame(-1, 0, -1, -1);
        check("done_count_s4", done_cnt, 4);

        // 5: reset after pixel 20
        run_frame(-1, 0, -1, 21);
        rst = 1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_s_ready", s_ready, 0);
        check("abort_win_valid", win_valid, 0);
        check("abort_frame_done", frame_done, 0);
        tick();
        rst = 0;
        repeat (5) tick();
        check("abort_no_done", done_cnt, 4);
        run_frame(-1, 0, -1, -1);
        check("done_count_s5", done_cnt, 5);

`ifdef LB_CTRL_STATS_EN
        // 6: statistics over two frames with one 5-cycle stall
        rst = 1;
        tick();
        rst = 0;
        tick();
        run_frame(-1, 0, -1, -1);
        run_frame(21, 5, -1, -1);
        check("stats_frame_count", frame_count, 2);
        check("stats_stall_count", stall_count, 5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/line_buffer_ctrl.md
Name: line_buffer_ctrl

Overview:
Frame-level sequencer for the line-buffer chain that feeds the HOG kernel/gradient stage. Accepts a raster pixel stream and forwards it into the first line-buffer FIFO under a valid/ready handshake. Tracks column and row of every accepted pixel, and sequences the frame through idle, line-fill, run and done phases. Produces per-pixel window qualifiers (window valid, border, window coordinates) aligned with the one-cycle BRAM read latency of the line buffers.

Parameters:
DATA_WIDTH, 8, pixel width in bits
IMG_WIDTH, 854, pixels per row (at least KERNEL_WIDTH)
IMG_HEIGHT, 480, rows per frame (at least KERNEL_WIDTH)
KERNEL_WIDTH, 3, square kernel size; line-buffer chain depth is KERNEL_WIDTH-1
XW, $clog2(IMG_WIDTH), column counter width (localparam)
YW, $clog2(IMG_HEIGHT), row counter width (localparam)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
start  input  1  single-cycle pulse; begins a frame when idle
s_data  input  DATA_WIDTH  upstream pixel
s_valid  input  1  upstream pixel valid
s_ready  output  1  controller can accept a pixel
lb_w_data  output  DATA_WIDTH  pixel to first line buffer (equals s_data)
lb_w_valid  output  1  write strobe to line buffer
lb_w_ready  input  1  line-buffer chain ready (downstream r_ready)
busy  output  1  high in FILL or RUN
win_valid  output  1  registered; kernel window complete and legal this cycle
win_border  output  1  registered; window wraps a row edge, no kernel operation
win_x  output  XW  registered; window top-left column
win_y  output  YW  registered; window top-left row
frame_done  output  1  single-cycle pulse after last pixel accepted

Behaviour:
- Reset: state IDLE; col, row = 0; busy, win_valid, win_border, frame_done = 0; win_x, win_y = 0. Reset mid-frame aborts immediately; no done pulse.
- States:
  - IDLE: start goes to FILL, with col, row cleared.
  - FILL: exits to RUN on acceptance of pixel (row KERNEL_WIDTH-2, col IMG_WIDTH-1).
  - RUN: exits to DONE on acceptance of pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
  - DONE: lasts one cycle with frame_done=1, then returns to IDLE.
- start is ignored outside IDLE.
- Handshake:
  - s_ready = lb_w_ready and state in {FILL, RUN} (combinational).
  - accept = s_valid and s_ready; lb_w_valid = accept; lb_w_data = s_data.
  - The controller never drops or duplicates a pixel. With s_valid low or lb_w_ready low, counters hold and no window output is produced.
- Counters: advance only on accept.
  - col wraps from IMG_WIDTH-1 to 0; at the wrap, row increments.
  - row wraps to 0 at end of frame.
  - Comparisons are done at full counter width, with no truncation.
- Window qualifiers are registered, one cycle after accept, to align with line-buffer read data:
  - win_valid = accept in RUN and col >= KERNEL_WIDTH-1.
  - win_border = accept in RUN and col < KERNEL_WIDTH-1 (window spans previous row end).
  - win_valid and win_border are mutually exclusive.
  - win_x = col-(KERNEL_WIDTH-1), win_y = row-(KERNEL_WIDTH-1) when win_valid; otherwise both 0.
  - All are 0 on non-accept cycles.
- Stale line-buffer contents from a prior frame are never qualified: win_valid is 0 throughout FILL.
- Last pixel: its window output and DONE both appear in the following cycle, i.e. win_valid=1 coincides with frame_done=1.
- Per frame: win_valid count = (IMG_WIDTH-K+1)*(IMG_HEIGHT-K+1); win_border count = (K-1)*(IMG_HEIGHT-K+1).

Optional Feature:
LB_CTRL_STATS_EN defined:
- Adds outputs frame_count (16 bits) and stall_count (32 bits).
- frame_count increments on each frame_done and wraps.
- stall_count counts busy cycles with s_valid=1 and lb_w_ready=0; it clears on start and saturates at all-ones.
- Both reset to 0.
LB_CTRL_STATS_EN undefined: these ports and registers are absent; behaviour otherwise identical.

Test Plan:
All scenarios use IMG_WIDTH=8, IMG_HEIGHT=6, KERNEL_WIDTH=3.
1. Assert rst with clk running -> s_ready=0, busy=0, all win_* and frame_done=0; deassert, no start -> lb_w_valid stays 0 for 20 cycles.
2. start, then 48 back-to-back pixels -> busy after start, first win_valid one cycle after pixel 18 with win_x=0, win_y=0. Totals: 24 win_valid, 8 win_border (pixels 16,17,24,25,32,33,40,41), frame_done exactly once, coincident with win_valid for win_x=5, win_y=3.
3. Mid-row pixel 21 with lb_w_ready=0 for 5 cycles -> s_ready=0, lb_w_valid=0, col/row hold, no win outputs; resume -> totals identical to scenario 2.
4. start pulsed at pixel 10 of a frame -> ignored, frame completes normally; a second start after frame_done -> second frame reproduces the same 24/8 counts.
5. rst asserted after pixel 20 -> next cycle all outputs 0, state IDLE, s_ready=0, no frame_done; a new frame after start completes correctly.
6. LB_CTRL_STATS_EN: two frames with a 5-cycle stall in the second -> frame_count=2, stall_count=5.
